// File: rtl/switch_hex_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : switch_seq_pkg
//  Brief    : Shared state encoding, ASCII constants and nibble-to-hex
//             conversion for the switch hex sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package switch_seq_pkg;

    // Scan sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SEND    = 3'd2,
        NEWLINE = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    localparam logic [7:0] ASCII_ZERO      = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;  // 'A' - 10
    localparam logic [7:0] ASCII_LF        = 8'h0A;

    // Uppercase ASCII hex digit for a 4-bit value
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib <= 4'd9) begin
            return ASCII_ZERO + {4'h0, nib};
        end else begin
            return ASCII_ALPHA_OFS + {4'h0, nib};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_hex_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : switch_hex_sequencer
//  Brief    : Walks the nibble-mux select 3..0, samples each nibble after a
//             settle delay and streams it as an uppercase ASCII hex digit to a
//             valid/ready UART byte interface, optionally followed by LF.
//             The completed 16-bit word is published as a snapshot.
//  Revision : 1.0 - initial release
// ============================================================================
module switch_hex_sequencer
    import switch_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,   // legal range 1..15
    parameter int APPEND_NEWLINE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic [1:0]  mux,
    input  logic [3:0]  selected_switches,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done,
    output logic [15:0] snapshot
);

    // Last settle-count value before sampling
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam bit         c_NEWLINE     = (APPEND_NEWLINE != 0);

    seq_state_t  r_state;
    logic [1:0]  r_index;
    logic [3:0]  r_settle;
    logic [15:0] r_shadow;
    logic [1:0]  r_mux;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_snapshot;

    // Scan FSM: every output is a register updated alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_index    <= 2'd3;
            r_settle   <= 4'd0;
            r_shadow   <= 16'h0000;
            r_mux      <= 2'b00;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_snapshot <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SELECT;
                        r_index  <= 2'd3;
                        r_mux    <= 2'b11;
                        r_settle <= 4'd0;
                        r_busy   <= 1'b1;
                    end
                end

                SELECT: begin
                    if (r_settle == c_SETTLE_LAST) begin
                        // Mux output has settled: capture nibble and present it
                        r_settle <= 4'd0;
                        case (r_index)
                            2'd3:    r_shadow[15:12] <= selected_switches;
                            2'd2:    r_shadow[11:8]  <= selected_switches;
                            2'd1:    r_shadow[7:4]   <= selected_switches;
                            default: r_shadow[3:0]   <= selected_switches;
                        endcase
                        r_tx_data  <= nibble_to_ascii(selected_switches);
                        r_tx_valid <= 1'b1;
                        r_state    <= SEND;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end

                SEND: begin
                    // tx_valid is high throughout SEND, so tx_ready is the handshake
                    if (tx_ready) begin
                        if (r_index != 2'd0) begin
                            r_index    <= r_index - 2'd1;
                            r_mux      <= r_index - 2'd1;
                            r_tx_valid <= 1'b0;
                            r_state    <= SELECT;
                        end else if (c_NEWLINE) begin
                            r_tx_data <= ASCII_LF;
                            r_state   <= NEWLINE;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_snapshot <= r_shadow;
                            r_state    <= DONE;
                        end
                    end
                end

                NEWLINE: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_done     <= 1'b1;
                        r_snapshot <= r_shadow;
                        r_state    <= DONE;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_mux   <= 2'b00;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign mux      = r_mux;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign done     = r_done;
    assign snapshot = r_snapshot;

endmodule
`default_nettype wire

// File: tb/tb_switch_hex_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_switch_hex_sequencer
//  Brief    : Directed self-checking bench for switch_hex_sequencer, default
//             build plus a SETTLE_CYCLES=1 / no-newline build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_switch_hex_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start_b = 1'b0;
    logic        tx_ready = 1'b1, tx_ready_b = 1'b1;
    logic [15:0] sw = 16'h0000, sw_b = 16'h0000;
    logic [3:0]  sel, sel_b;

    logic        busy, tx_valid, done;
    logic [1:0]  mux;
    logic [7:0]  tx_data;
    logic [15:0] snapshot;
    logic        busy_b, tx_valid_b, done_b;
    logic [1:0]  mux_b;
    logic [7:0]  tx_data_b;
    logic [15:0] snapshot_b;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int t0 = 0;

    logic [7:0] byte_q[$];
    logic [1:0] mux_q[$];
    logic [7:0] byte_q_b[$];
    int done_cnt = 0, done_cyc = -1, first_valid = -1;
    int done_cnt_b = 0, done_cyc_b = -1;

    switch_hex_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .mux(mux),
        .selected_switches(sel), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .done(done), .snapshot(snapshot)
    );

    switch_hex_sequencer #(.SETTLE_CYCLES(1), .APPEND_NEWLINE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .mux(mux_b),
        .selected_switches(sel_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .done(done_b), .snapshot(snapshot_b)
    );

    // Behavioural stand-in for the 16-to-4 nibble mux
    function automatic logic [3:0] pick(input logic [15:0] w, input logic [1:0] s);
        case (s)
            2'b00:   return w[3:0];
            2'b01:   return w[7:4];
            2'b10:   return w[11:8];
            default: return w[15:12];
        endcase
    endfunction

    always_comb sel   = pick(sw, mux);
    always_comb sel_b = pick(sw_b, mux_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record handshaken bytes and done pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            byte_q.push_back(tx_data);
            mux_q.push_back(mux);
        end
        if (tx_valid && first_valid < 0) first_valid = cyc - t0;
        if (done) begin
            done_cnt++;
            done_cyc = cyc - t0;
        end
        if (tx_valid_b && tx_ready_b) byte_q_b.push_back(tx_data_b);
        if (done_b) begin
            done_cnt_b++;
            done_cyc_b = cyc - t0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; on return the bench sits in cycle 1
    task automatic start_scan(input bit which);
        if (which) start_b = 1'b1; else start = 1'b1;
        t0 = cyc;
        byte_q.delete(); mux_q.delete(); byte_q_b.delete();
        done_cnt = 0; done_cyc = -1; first_valid = -1;
        done_cnt_b = 0; done_cyc_b = -1;
        step();
        start = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_not_busy(input bit which, input int budget, output bit timed_out);
        int n = 0;
        while ((which ? busy_b : busy) && n < budget) begin
            step();
            n++;
        end
        timed_out = which ? busy_b : busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        tests_run++;
        if (mux !== 2'b00) begin tests_failed++; $display("FAIL reset_mux: got %b expected 00", mux); end
        tests_run++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ctrl: valid/busy/done got %b%b%b expected 000", tx_valid, busy, done);
        end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_txdata: got %h expected 00", tx_data); end
        tests_run++;
        if (snapshot !== 16'h0000) begin tests_failed++; $display("FAIL reset_snapshot: got %h expected 0000", snapshot); end
        tests_run++;
        if (busy_b !== 1'b0 || tx_valid_b !== 1'b0) begin
            tests_failed++; $display("FAIL reset_b: busy/valid got %b%b expected 00", busy_b, tx_valid_b);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] exp[5];
        logic [1:0] exp_mux[5];
        logic [7:0] got;
        logic [1:0] got_m;
        bit to;
        exp     = '{8'h31, 8'h41, 8'h33, 8'h46, 8'h0A};
        exp_mux = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        sw = 16'h1A3F;
        tx_ready = 1'b1;
        start_scan(1'b0);
        tests_run++;
        if (mux !== 2'b11 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL basic_cycle1: mux/busy got %b/%b expected 11/1", mux, busy);
        end
        wait_not_busy(1'b0, 100, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: busy stuck got 1 expected 0"); end
        tests_run++;
        if (cyc - t0 !== 15) begin tests_failed++; $display("FAIL basic_busy_fall: cycle got %0d expected 15", cyc - t0); end
        tests_run++;
        if (first_valid !== 3) begin tests_failed++; $display("FAIL basic_first_valid: cycle got %0d expected 3", first_valid); end
        tests_run++;
        if (byte_q.size() !== 5) begin tests_failed++; $display("FAIL basic_count: got %0d bytes expected 5", byte_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got   = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            got_m = (i < mux_q.size()) ? mux_q[i] : 2'bxx;
            tests_run++;
            if (got !== exp[i] || got_m !== exp_mux[i]) begin
                tests_failed++;
                $display("FAIL basic_byte%0d: got %h/mux %b expected %h/mux %b", i, got, got_m, exp[i], exp_mux[i]);
            end
        end
        tests_run++;
        if (done_cnt !== 1 || done_cyc !== 14) begin
            tests_failed++; $display("FAIL basic_done: count %0d cycle %0d expected 1 and 14", done_cnt, done_cyc);
        end
        tests_run++;
        if (snapshot !== 16'h1A3F) begin tests_failed++; $display("FAIL basic_snapshot: got %h expected 1A3F", snapshot); end
    endtask

    task automatic test_stall();
        bit to;
        int n = 0;
        sw = 16'h1A3F;
        tx_ready = 1'b0;
        start_scan(1'b0);
        while (!tx_valid && n < 20) begin step(); n++; end
        tests_run++;
        if (cyc - t0 !== 3) begin tests_failed++; $display("FAIL stall_first_valid: cycle got %0d expected 3", cyc - t0); end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({tx_valid, tx_data, mux} !== {1'b1, 8'h31, 2'b11}) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: valid/data/mux got %b/%h/%b expected 1/31/11", i, tx_valid, tx_data, mux);
            end
            step();
        end
        tx_ready = 1'b1;
        wait_not_busy(1'b0, 100, to);
        tests_run++;
        if (to !== 1'b0 || done_cyc !== 19) begin
            tests_failed++; $display("FAIL stall_done: timeout %b cycle %0d expected 0 and 19", to, done_cyc);
        end
        tests_run++;
        if (byte_q.size() !== 5 || (byte_q.size() > 0 && byte_q[0] !== 8'h31)) begin
            tests_failed++; $display("FAIL stall_bytes: got %0d bytes expected 5 starting 31", byte_q.size());
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        sw = 16'h1A3F;
        tx_ready = 1'b1;
        start_scan(1'b0);
        while (cyc - t0 < 3) step();
        start = 1'b1; step(); start = 1'b0;
        while (cyc - t0 < 9) step();
        start = 1'b1; step(); start = 1'b0;
        wait_not_busy(1'b0, 100, to);
        tests_run++;
        if (to !== 1'b0 || cyc - t0 !== 15) begin
            tests_failed++; $display("FAIL ignore_end: timeout %b cycle %0d expected 0 and 15", to, cyc - t0);
        end
        tests_run++;
        if (byte_q.size() !== 5 || done_cnt !== 1) begin
            tests_failed++; $display("FAIL ignore_count: bytes %0d done %0d expected 5 and 1", byte_q.size(), done_cnt);
        end
        // Cycle right after DONE: a new scan must start
        start_scan(1'b0);
        tests_run++;
        if (busy !== 1'b1 || mux !== 2'b11) begin
            tests_failed++; $display("FAIL restart_launch: busy/mux got %b/%b expected 1/11", busy, mux);
        end
        wait_not_busy(1'b0, 100, to);
        tests_run++;
        if (to !== 1'b0 || done_cyc !== 14 || byte_q.size() !== 5) begin
            tests_failed++; $display("FAIL restart_scan: timeout %b done %0d bytes %0d expected 0/14/5", to, done_cyc, byte_q.size());
        end
    endtask

    task automatic test_midchange();
        logic [7:0] exp[5];
        logic [7:0] got;
        bit to;
        exp = '{8'h46, 8'h30, 8'h30, 8'h30, 8'h0A};
        sw = 16'hFFFF;
        tx_ready = 1'b1;
        start_scan(1'b0);
        while (cyc - t0 < 4) step();
        sw = 16'h0000;
        wait_not_busy(1'b0, 100, to);
        tests_run++;
        if (to !== 1'b0 || byte_q.size() !== 5) begin
            tests_failed++; $display("FAIL change_count: timeout %b bytes %0d expected 0 and 5", to, byte_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            tests_run++;
            if (got !== exp[i]) begin tests_failed++; $display("FAIL change_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
        tests_run++;
        if (snapshot !== 16'hF000) begin tests_failed++; $display("FAIL change_snapshot: got %h expected F000", snapshot); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[5];
        logic [7:0] got;
        bit to;
        exp = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
        sw = 16'h1A3F;
        tx_ready = 1'b1;
        start_scan(1'b0);
        while (cyc - t0 < 6) step();
        tests_run++;
        if (tx_valid !== 1'b1 || mux !== 2'b10) begin
            tests_failed++; $display("FAIL rstmid_send: valid/mux got %b/%b expected 1/10", tx_valid, mux);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({mux, tx_valid, busy} !== 4'b0000 || snapshot !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstmid_async: mux/valid/busy/snap got %b/%b/%b/%h expected 00/0/0/0000", mux, tx_valid, busy, snapshot);
        end
        step(); step();
        rst = 1'b0;
        step();
        sw = 16'hBEEF;
        start_scan(1'b0);
        tests_run++;
        if (mux !== 2'b11) begin tests_failed++; $display("FAIL rstmid_index: mux got %b expected 11", mux); end
        wait_not_busy(1'b0, 100, to);
        tests_run++;
        if (to !== 1'b0 || byte_q.size() !== 5 || done_cyc !== 14) begin
            tests_failed++; $display("FAIL rstmid_rescan: timeout %b bytes %0d done %0d expected 0/5/14", to, byte_q.size(), done_cyc);
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            tests_run++;
            if (got !== exp[i]) begin tests_failed++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
        tests_run++;
        if (snapshot !== 16'hBEEF) begin tests_failed++; $display("FAIL rstmid_snapshot: got %h expected BEEF", snapshot); end
    endtask

    task automatic test_no_newline();
        logic [7:0] exp[4];
        logic [7:0] got;
        bit to;
        exp = '{8'h42, 8'h45, 8'h45, 8'h46};
        sw_b = 16'hBEEF;
        tx_ready_b = 1'b1;
        start_scan(1'b1);
        wait_not_busy(1'b1, 100, to);
        tests_run++;
        if (to !== 1'b0 || byte_q_b.size() !== 4) begin
            tests_failed++; $display("FAIL nonl_count: timeout %b bytes %0d expected 0 and 4", to, byte_q_b.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < byte_q_b.size()) ? byte_q_b[i] : 8'hxx;
            tests_run++;
            if (got !== exp[i]) begin tests_failed++; $display("FAIL nonl_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
        tests_run++;
        if (done_cnt_b !== 1 || done_cyc_b !== 9) begin
            tests_failed++; $display("FAIL nonl_done: count %0d cycle %0d expected 1 and 9", done_cnt_b, done_cyc_b);
        end
        tests_run++;
        if (snapshot_b !== 16'hBEEF) begin tests_failed++; $display("FAIL nonl_snapshot: got %h expected BEEF", snapshot_b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_midchange();
        test_reset_mid();
        test_no_newline();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
